// File: rtl/add_sub_multicycle.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, carry rippled through a register.
// Results, flags and the done pulse appear NCHUNK cycles after start is accepted.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one chunk added per clock, idx selects the slice
// DONE  | outputs just loaded, done pulses; start here chains the next op
module add_sub_multicycle #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] sum,
   output logic             Cout,
   output logic             ovf,
   output logic             zero,
   output logic             busy,
   output logic             done
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] work_next;
   logic             carry;
   logic [IW-1:0]    idx;
   logic [31:0]      shamt;
   logic [CHUNK-1:0] a_sl;
   logic [CHUNK-1:0] b_sl;
   logic [CHUNK-1:0] s_sl;
   logic [CHUNK:0]   chunk_sum;
   logic             c_msb;
   logic             accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (idx == LAST_IDX) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   assign accept = start && ((state == IDLE) || (state == DONE));

   // Slice select by shifting keeps the index arithmetic width-clean for any CHUNK.
   always_comb begin
      shamt     = 32'(idx) * 32'(CHUNK);
      a_sl      = CHUNK'(op_a >> shamt);
      b_sl      = CHUNK'(op_b >> shamt);
      chunk_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
      s_sl      = chunk_sum[CHUNK-1:0];
      // Carry into the top bit recovered from the sum bit: s = a ^ b ^ cin.
      c_msb     = s_sl[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];
      work_next = (work & ~(SLICE_MASK << shamt)) | (WIDTH'(s_sl) << shamt);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a  <= '0;
         op_b  <= '0;
         work  <= '0;
         carry <= 1'b0;
         idx   <= '0;
         sum   <= '0;
         Cout  <= 1'b0;
         ovf   <= 1'b0;
         zero  <= 1'b0;
      end else if (accept) begin
         op_a  <= A;
         op_b  <= sub ? ~B : B;
         carry <= sub | Cin;
         idx   <= '0;
      end else if (state == RUN) begin
         work  <= work_next;
         carry <= chunk_sum[CHUNK];
         if (idx == LAST_IDX) begin
            idx  <= '0;
            sum  <= work_next;
            Cout <= chunk_sum[CHUNK];
            ovf  <= c_msb ^ chunk_sum[CHUNK];
            zero <= ~|work_next;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_add_sub_multicycle.sv
// Scoreboard bench: directed cases on a 32/8 instance plus random sweeps over
// several WIDTH/CHUNK configurations, checked against an integer-arithmetic model.
module tb_add_sub_multicycle;
   localparam int NOPS = 1000;
   localparam int NCFG = 6;
   localparam int CW[NCFG] = '{8, 8, 8, 32, 32, 32};
   localparam int CC[NCFG] = '{1, 4, 8, 1, 4, 32};

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      int          t;
   } exp_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   sweep_fin = 0;
   logic main_fin = 1'b0;
   logic sweep_rst;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic flag(input string nm, input string why);
      checks++;
      errors++;
      $display("FAIL %s %s (t=%0t)", nm, why, $time);
   endtask

   // Reference: plain integer arithmetic on w-bit operands.
   function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic s, input logic ci);
      exp_t e;
      longint unsigned mask, ua, ub, tot;
      longint sa, sb, res, lim;
      mask = (64'd1 << w) - 64'd1;
      ua   = 64'(a) & mask;
      ub   = 64'(b) & mask;
      sa   = a[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
      sb   = b[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
      lim  = longint'(1) << (w - 1);
      if (s) begin
         tot    = ua - ub;
         e.cout = (ua >= ub);
         res    = sa - sb;
      end else begin
         tot    = ua + ub + 64'(ci);
         e.cout = ((tot >> w) & 64'd1) != 64'd0;
         res    = sa + sb + longint'(ci);
      end
      e.sum  = 32'(tot & mask);
      e.ovf  = (res >= lim) || (res < -lim);
      e.zero = ((tot & mask) == 64'd0);
      e.t    = 0;
      return e;
   endfunction

   function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o, input logic z);
      exp_t e;
      e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.t = 0;
      return e;
   endfunction

   // ---------------- main 32/8 instance ----------------
   logic        m_rst, m_start, m_sub, m_cin;
   logic [31:0] m_a, m_b, m_sum;
   logic        m_cout, m_ovf, m_zero, m_busy, m_done;
   exp_t        mq[$];
   logic [31:0] last_sum;
   logic        last_cout, last_ovf, last_zero;
   int          brun;
   int          m_last_done_cyc = 0;

   add_sub_multicycle #(.WIDTH(32), .CHUNK(8)) dut_main (
      .clk(clk), .rst(m_rst), .start(m_start), .sub(m_sub), .A(m_a), .B(m_b), .Cin(m_cin),
      .sum(m_sum), .Cout(m_cout), .ovf(m_ovf), .zero(m_zero), .busy(m_busy), .done(m_done)
   );

   initial begin : main_mon
      exp_t e;
      last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0; last_zero = 1'b0; brun = 0;
      forever begin
         @(negedge clk);
         if (m_rst) begin
            last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0; last_zero = 1'b0; brun = 0;
         end else if (m_done) begin
            if (mq.size() == 0) begin
               flag("main_done", "done with no request outstanding");
            end else begin
               e = mq.pop_front();
               check("main_sum", 64'(m_sum), 64'(e.sum));
               check("main_cout", 64'(m_cout), 64'(e.cout));
               check("main_ovf", 64'(m_ovf), 64'(e.ovf));
               check("main_zero", 64'(m_zero), 64'(e.zero));
               check("main_latency", 64'(cyc - e.t), 64'd4);
               check("main_busy_cycles", 64'(brun), 64'd4);
            end
            m_last_done_cyc = cyc;
            last_sum = m_sum; last_cout = m_cout; last_ovf = m_ovf; last_zero = m_zero;
            brun = 0;
         end else if (m_busy) begin
            brun++;
            check("main_hold_in_run", 64'({m_sum, m_cout, m_ovf, m_zero}),
                  64'({last_sum, last_cout, last_ovf, last_zero}));
         end
      end
   end

   task automatic m_drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic ci, input exp_t e);
      exp_t x;
      x = e;
      m_a = a; m_b = b; m_sub = s; m_cin = ci; m_start = 1'b1;
      x.t = cyc + 1;
      mq.push_back(x);
      @(negedge clk);
      m_start = 1'b0; m_a = $urandom(); m_b = $urandom(); m_sub = ~s; m_cin = ~ci;
   endtask

   task automatic m_issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic ci, input exp_t e);
      @(negedge clk);
      m_drive(a, b, s, ci, e);
   endtask

   task automatic m_wait();
      int g;
      g = 0;
      while (mq.size() != 0 && g < 100) begin
         @(posedge clk);
         g++;
      end
      if (g >= 100) begin
         flag("main_wait", "timed out waiting for done");
         mq.delete();
      end
   endtask

   initial begin : main_drv
      logic [31:0] ra, rb;
      logic        rs, rc;
      int          d1, g;
      m_rst = 1'b1; sweep_rst = 1'b1;
      m_start = 1'b0; m_sub = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0;
      #12;
      check("reset_outputs", 64'({m_sum, m_cout, m_ovf, m_zero, m_busy, m_done}), 64'd0);
      #11;
      m_rst = 1'b0; sweep_rst = 1'b0;

      m_issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1)); m_wait();
      m_issue(32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0)); m_wait();
      m_issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, mk(32'h2345_6789, 1'b0, 1'b0, 1'b0)); m_wait();
      m_issue(32'd5, 32'd7, 1'b1, 1'b0, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0)); m_wait();
      m_issue(32'h8000_0000, 32'd1, 1'b1, 1'b0, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0)); m_wait();
      m_issue(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1)); m_wait();
      m_issue(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1, mk(32'h0, 1'b1, 1'b0, 1'b1)); m_wait();

      // start re-asserted with other operands through the rest of RUN
      m_issue(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0, mk(32'h0000_1234, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         m_start = 1'b1; m_a = $urandom(); m_b = $urandom(); m_sub = 1'($urandom_range(1));
      end
      @(negedge clk);
      m_start = 1'b0;
      m_wait();

      // start in the DONE cycle chains the next operation
      m_issue(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
      g = 0;
      while (!m_done && g < 20) begin
         @(negedge clk);
         g++;
      end
      if (g >= 20) flag("b2b_first_done", "timed out");
      d1 = cyc;
      m_drive(32'h10, 32'h3, 1'b1, 1'b0, mk(32'hD, 1'b1, 1'b0, 1'b0));
      check("b2b_busy", 64'(m_busy), 64'd1);
      m_wait();
      check("b2b_gap", 64'(m_last_done_cyc - d1), 64'd5);

      // asynchronous abort after two RUN edges
      m_issue(32'd3, 32'd4, 1'b0, 1'b0, mk(32'd7, 1'b0, 1'b0, 1'b0));
      @(posedge clk);
      @(posedge clk);
      #2 m_rst = 1'b1;
      #1 check("abort_outputs", 64'({m_sum, m_cout, m_ovf, m_zero, m_busy, m_done}), 64'd0);
      mq.delete();
      @(negedge clk);
      #2 m_rst = 1'b0;
      repeat (8) @(negedge clk);
      check("abort_idle", 64'({m_busy, m_done}), 64'd0);
      m_issue(32'h0000_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h0001_0000, 1'b0, 1'b0, 1'b0)); m_wait();

      for (int n = 0; n < 40; n++) begin
         ra = $urandom(); rb = $urandom();
         rs = 1'($urandom_range(1)); rc = 1'($urandom_range(1));
         if (n % 5 == 0) rb = ra;
         m_issue(ra, rb, rs, rc, model(32, ra, rb, rs, rc));
         m_wait();
      end
      main_fin = 1'b1;
   end

   // ---------------- randomized configuration sweep ----------------
   for (genvar g = 0; g < NCFG; g++) begin : sw
      localparam int W = CW[g];
      localparam int C = CC[g];
      localparam int N = W / C;
      logic [W-1:0] a, b, s_sum;
      logic         st, s_sub, cin, co, ov, zr, bz, dn;
      exp_t         q[$];

      add_sub_multicycle #(.WIDTH(W), .CHUNK(C)) dut (
         .clk(clk), .rst(sweep_rst), .start(st), .sub(s_sub), .A(a), .B(b), .Cin(cin),
         .sum(s_sum), .Cout(co), .ovf(ov), .zero(zr), .busy(bz), .done(dn)
      );

      initial begin : drv
         exp_t e;
         int   guard, gap;
         st = 1'b0; a = '0; b = '0; s_sub = 1'b0; cin = 1'b0;
         #1;
         wait (sweep_rst == 1'b0);
         @(negedge clk);
         for (int n = 0; n < NOPS; n++) begin
            a = W'($urandom()); b = W'($urandom());
            s_sub = 1'($urandom_range(1)); cin = 1'($urandom_range(1));
            if (n % 10 == 1) a = '1;
            if (n % 10 == 2) b = a;
            if (n % 10 == 3) b = ~a;
            e = model(W, 32'(a), 32'(b), s_sub, cin);
            e.t = cyc + 1;
            q.push_back(e);
            st = 1'b1;
            @(negedge clk);
            st = 1'b0; a = W'($urandom()); b = W'($urandom()); s_sub = ~s_sub; cin = ~cin;
            guard = 0;
            while (bz && guard < 100) begin
               @(negedge clk);
               guard++;
            end
            if (guard >= 100) begin
               flag($sformatf("w%0d_c%0d_busy", W, C), "timed out");
               break;
            end
            gap = $urandom_range(2);
            repeat (gap) @(negedge clk);
         end
         guard = 0;
         while (q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
         end
         if (guard >= 100) flag($sformatf("w%0d_c%0d_drain", W, C), "timed out");
         sweep_fin++;
      end

      initial begin : mon
         exp_t e;
         forever begin
            @(negedge clk);
            if (sweep_rst == 1'b0 && dn) begin
               if (q.size() == 0) begin
                  flag($sformatf("w%0d_c%0d_done", W, C), "done with no request outstanding");
               end else begin
                  e = q.pop_front();
                  check($sformatf("w%0d_c%0d_sum", W, C), 64'(s_sum), 64'(e.sum));
                  check($sformatf("w%0d_c%0d_cout", W, C), 64'(co), 64'(e.cout));
                  check($sformatf("w%0d_c%0d_ovf", W, C), 64'(ov), 64'(e.ovf));
                  check($sformatf("w%0d_c%0d_zero", W, C), 64'(zr), 64'(e.zero));
                  check($sformatf("w%0d_c%0d_latency", W, C), 64'(cyc - e.t), 64'(N));
               end
            end
         end
      end
   end

   initial begin : finisher
      int g;
      g = 0;
      #30;
      while ((!main_fin || sweep_fin < NCFG) && g < 200000) begin
         @(posedge clk);
         g++;
      end
      if (g >= 200000) flag("completion", "timed out");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
